// File: rtl/clk_sched_pkg.sv
// Shared definitions for the clk_tick_scheduler block.
//   cw_f          : width of a channel index, max(1, clog2(n)).
//   chan_state_t  : architectural state of one tick channel.
//   DefaultDiv / DefaultRun : reset divisor and run state.
package clk_sched_pkg;

    // Channel state fields are sized to the widest supported divisor; for narrower
    // WIDTH the upper bits are only ever loaded with zero.
    localparam int unsigned StateWidth = 32;

    localparam int unsigned DefaultDiv = 25;
    localparam bit          DefaultRun = 1'b1;

    typedef struct packed {
        logic [StateWidth-1:0] cnt;
        logic [StateWidth-1:0] div;
        logic [StateWidth-1:0] nxt;
        logic                  run;
        logic                  pend;
        logic                  sq;
    } chan_state_t;

    function automatic int unsigned cw_f(input int unsigned n);
        return (n <= 2) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/clk_tick_scheduler_if.sv
// Config write port of clk_tick_scheduler: valid/ready handshake carrying a target
// channel, a divisor and a run flag.
//   master : drives cfg_valid, cfg_chan, cfg_div, cfg_run; samples cfg_ready.
//   slave  : the scheduler; drives cfg_ready.
interface clk_tick_scheduler_if
    import clk_sched_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 16
) ();
    localparam int unsigned CW = cw_f(CHANNELS);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CW-1:0]    cfg_chan;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_run;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_div,
        output cfg_run,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_div,
        input  cfg_run,
        output cfg_ready
    );
endinterface

// File: rtl/clk_sched_chan.sv
// One tick channel: programmable up-counter with wrap detect, deferred divisor
// latch, single-step while stopped, and a square output toggling on every tick.
//   clk, reset : system clock, synchronous active-high reset.
//   wr_en_i    : accepted config write for this channel (already gated by ready).
//   wr_div_i   : new divisor; wr_run_i : new run state.
//   step_i     : single-step request, honoured only while stopped.
//   tick_o     : registered one-cycle enable; sq_o : registered square output.
//   pend_o     : a deferred divisor is waiting for the next wrap.
module clk_sched_chan
    import clk_sched_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = DefaultDiv,
    parameter bit          RESET_RUN   = DefaultRun
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_div_i,
    input  logic             wr_run_i,
    input  logic             step_i,
    output logic             tick_o,
    output logic             sq_o,
    output logic             pend_o
);
    localparam chan_state_t ResetState = '{
        cnt:  '0,
        div:  StateWidth'(DEFAULT_DIV),
        nxt:  '0,
        run:  RESET_RUN,
        pend: 1'b0,
        sq:   1'b0
    };

    chan_state_t           state_q, state_d;
    logic                  tick_q, tick_d;
    logic [StateWidth-1:0] wr_div_ext;
    logic [StateWidth-1:0] eff_div;
    logic                  wrap;

    assign wr_div_ext = StateWidth'(wr_div_i);
    // Divisors 0 and 1 both mean "tick every cycle".
    assign eff_div    = (state_q.div == '0) ? StateWidth'(1) : state_q.div;
    assign wrap       = state_q.run && (state_q.cnt == eff_div - StateWidth'(1));

    always_comb begin
        state_d = state_q;
        tick_d  = 1'b0;

        if (state_q.run) begin
            if (wrap) begin
                tick_d        = 1'b1;
                state_d.cnt   = '0;
                if (state_q.pend) begin
                    state_d.div  = state_q.nxt;
                    state_d.pend = 1'b0;
                end
            end else begin
                state_d.cnt = state_q.cnt + StateWidth'(1);
            end
        end else if (step_i) begin
            tick_d = 1'b1;
        end

        if (wr_en_i) begin
            if (!wr_run_i) begin
                // Stop takes effect at once and swallows any tick on this edge.
                state_d.div  = wr_div_ext;
                state_d.cnt  = '0;
                state_d.run  = 1'b0;
                state_d.pend = 1'b0;
                tick_d       = 1'b0;
            end else if (!state_q.run) begin
                state_d.div = wr_div_ext;
                state_d.cnt = '0;
                state_d.run = 1'b1;
            end else if (wrap) begin
                // New period starts on this edge anyway, so no need to defer.
                state_d.div = wr_div_ext;
            end else begin
                state_d.nxt  = wr_div_ext;
                state_d.pend = 1'b1;
            end
        end

        if (tick_d) begin
            state_d.sq = ~state_q.sq;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ResetState;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = state_q.sq;
    assign pend_o = state_q.pend;

endmodule

// File: rtl/clk_tick_scheduler.sv
// Runtime-programmable clock-enable tick generator with CHANNELS independent channels.
//   clk, reset : system clock, synchronous active-high reset.
//   cfg        : config write port (slave side); one write accepted per cycle.
//   step       : per-channel single-step requests (level, used while stopped).
//   tick       : registered one-cycle enables; sq : registered square outputs.
//   pend       : per-channel deferred-divisor flags.
// cfg_ready is combinational from pend and cfg_chan; writes to channel numbers
// >= CHANNELS are accepted and dropped.
module clk_tick_scheduler
    import clk_sched_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = DefaultDiv,
    parameter bit          RESET_RUN   = DefaultRun
) (
    input  logic                clk,
    input  logic                reset,
    clk_tick_scheduler_if.slave cfg,
    input  logic [CHANNELS-1:0] step,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] sq,
    output logic [CHANNELS-1:0] pend
);
    localparam int unsigned CW = cw_f(CHANNELS);

    logic cfg_ready_c;
    logic cfg_accept;

    always_comb begin
        cfg_ready_c = 1'b1;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (cfg.cfg_chan == CW'(i)) begin
                cfg_ready_c = ~pend[i];
            end
        end
        if (reset) begin
            cfg_ready_c = 1'b0;
        end
    end

    assign cfg.cfg_ready = cfg_ready_c;
    assign cfg_accept    = cfg.cfg_valid & cfg_ready_c;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic wr_en;
        assign wr_en = cfg_accept && (cfg.cfg_chan == CW'(g));

        clk_sched_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV),
            .RESET_RUN   (RESET_RUN)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .wr_en_i  (wr_en),
            .wr_div_i (cfg.cfg_div),
            .wr_run_i (cfg.cfg_run),
            .step_i   (step[g]),
            .tick_o   (tick[g]),
            .sq_o     (sq[g]),
            .pend_o   (pend[g])
        );
    end

endmodule

// File: tb/tb_clk_tick_scheduler.sv
// Bench for clk_tick_scheduler: directed scenarios plus randomized traffic checked
// against a countdown-based behavioural model of each channel.
module tb_clk_tick_scheduler;
    import clk_sched_pkg::*;

    localparam int unsigned CH   = 4;
    localparam int unsigned W    = 16;
    localparam int unsigned DDIV = 25;
    localparam bit          DRUN = 1'b1;
    localparam int unsigned CW   = cw_f(CH);

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] step  = '0;
    logic [CH-1:0] tick, sq, pend;

    clk_tick_scheduler_if #(.CHANNELS(CH), .WIDTH(W)) cfg_if ();

    clk_tick_scheduler #(
        .CHANNELS    (CH),
        .WIDTH       (W),
        .DEFAULT_DIV (DDIV),
        .RESET_RUN   (DRUN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cfg   (cfg_if),
        .step  (step),
        .tick  (tick),
        .sq    (sq),
        .pend  (pend)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: m_rem = edges still to go until the next tick of a running channel.
    int unsigned   m_div [CH];
    int unsigned   m_nxt [CH];
    int unsigned   m_rem [CH];
    logic [CH-1:0] m_run, m_pend, m_tick, m_sq;

    function automatic int unsigned eff(input int unsigned d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic logic exp_ready();
        if (reset) return 1'b0;
        if (int'(cfg_if.cfg_chan) < int'(CH)) return ~m_pend[cfg_if.cfg_chan];
        return 1'b1;
    endfunction

    task automatic set_cfg(input logic v, input int ch, input int d, input logic r);
        cfg_if.cfg_valid = v;
        cfg_if.cfg_chan  = CW'(ch);
        cfg_if.cfg_div   = W'(d);
        cfg_if.cfg_run   = r;
    endtask

    // Advance one rising edge, updating the model from the inputs seen at that edge.
    task automatic tick_clk();
        logic acc;
        acc = cfg_if.cfg_valid && exp_ready();
        @(posedge clk);
        for (int i = 0; i < int'(CH); i++) begin
            logic wr, was_run, wrap, t;
            int unsigned d;
            if (reset) begin
                m_div[i] = DDIV; m_nxt[i] = 0; m_rem[i] = eff(DDIV);
                m_run[i] = DRUN; m_pend[i] = 1'b0; m_tick[i] = 1'b0; m_sq[i] = 1'b0;
                continue;
            end
            wr      = acc && (int'(cfg_if.cfg_chan) == i);
            was_run = m_run[i];
            wrap    = was_run && (m_rem[i] == 1);
            t       = 1'b0;
            d       = int'(cfg_if.cfg_div);
            if (was_run) begin
                if (wrap) begin
                    t = 1'b1;
                    if (m_pend[i]) begin
                        m_div[i]  = m_nxt[i];
                        m_pend[i] = 1'b0;
                    end
                    m_rem[i] = eff(m_div[i]);
                end else begin
                    m_rem[i] = m_rem[i] - 1;
                end
            end else if (step[i]) begin
                t = 1'b1;
            end
            if (wr) begin
                if (!cfg_if.cfg_run) begin
                    m_div[i] = d; m_run[i] = 1'b0; m_pend[i] = 1'b0; t = 1'b0;
                end else if (!was_run) begin
                    m_div[i] = d; m_run[i] = 1'b1; m_rem[i] = eff(d);
                end else if (wrap) begin
                    m_div[i] = d; m_rem[i] = eff(d);
                end else begin
                    m_nxt[i] = d; m_pend[i] = 1'b1;
                end
            end
            m_tick[i] = t;
            if (t) m_sq[i] = ~m_sq[i];
        end
        #1;
    endtask

    task automatic cfg_write(input int ch, input int d, input logic r);
        set_cfg(1'b1, ch, d, r);
        tick_clk();
        set_cfg(1'b0, ch, d, r);
    endtask

    // Edges until tick[ch] is seen high; budget+1 when it never arrives.
    task automatic edges_to_tick(input int ch, input int budget, output int n,
                                 output logic pend_seen);
        n = budget + 1;
        pend_seen = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            tick_clk();
            if (pend[ch]) pend_seen = 1'b1;
            if (tick[ch]) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_cfg(1'b0, 0, 0, 1'b0);
        step = '0;
        repeat (3) begin
            tick_clk();
            n_vec++;
            if ({cfg_if.cfg_ready, tick, sq, pend} !== '0) begin
                n_err++;
                $display("FAIL reset_state: ready=%b tick=%b sq=%b pend=%b, required all 0",
                         cfg_if.cfg_ready, tick, sq, pend);
            end
        end
        reset = 1'b0;
        for (int e = 1; e <= 75; e++) begin
            logic [1:0] exp;
            tick_clk();
            exp = {(e % 25) == 0, ((e / 25) % 2) == 1};
            n_vec++;
            if ({tick[0], sq[0]} !== exp) begin
                n_err++;
                $display("FAIL reset_default_div: edge E%0d tick/sq=%b, required %b",
                         e, {tick[0], sq[0]}, exp);
            end
        end
    endtask

    task automatic test_deferred();
        int n;
        logic ps;
        cfg_write(1, 4, 1'b0);
        cfg_write(1, 4, 1'b1);
        tick_clk();
        cfg_write(1, 10, 1'b1);
        #1;
        n_vec++;
        if ({pend[1], cfg_if.cfg_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL deferred_pend: pend/ready=%b, required 10", {pend[1], cfg_if.cfg_ready});
        end
        edges_to_tick(1, 20, n, ps);
        n_vec++;
        if (n !== 2 || pend[1] !== 1'b0) begin
            n_err++;
            $display("FAIL deferred_first: edges=%0d pend=%b, required 2 and 0", n, pend[1]);
        end
        repeat (2) begin
            edges_to_tick(1, 20, n, ps);
            n_vec++;
            if (n !== 10) begin
                n_err++;
                $display("FAIL deferred_period: period=%0d, required 10", n);
            end
        end
    endtask

    task automatic test_div01();
        for (int d = 0; d <= 1; d++) begin
            cfg_write(2, d, 1'b0);
            cfg_write(2, d, 1'b1);
            repeat (5) begin
                tick_clk();
                n_vec++;
                if (tick[2] !== 1'b1) begin
                    n_err++;
                    $display("FAIL div%0d_every_cycle: tick=%b, required 1", d, tick[2]);
                end
            end
        end
    endtask

    task automatic test_step();
        int ticks, toggles;
        logic prev;
        logic [6:0] pat;
        cfg_write(3, 25, 1'b0);
        ticks = 0;
        repeat (30) begin
            tick_clk();
            if (tick[3]) ticks++;
        end
        n_vec++;
        if (ticks !== 0) begin
            n_err++;
            $display("FAIL stopped_silent: ticks=%0d, required 0", ticks);
        end
        // step pattern per edge: 1,0,0,1,1,1,0
        pat = 7'b1001110;
        toggles = 0;
        prev = sq[3];
        for (int k = 0; k < 7; k++) begin
            step[3] = pat[6-k];
            tick_clk();
            if (sq[3] !== prev) toggles++;
            prev = sq[3];
            n_vec++;
            if (tick[3] !== pat[6-k]) begin
                n_err++;
                $display("FAIL step_tick: edge %0d tick=%b, required %b", k, tick[3], pat[6-k]);
            end
        end
        step[3] = 1'b0;
        n_vec++;
        if (toggles !== 4) begin
            n_err++;
            $display("FAIL step_sq_toggles: toggles=%0d, required 4", toggles);
        end
    endtask

    task automatic test_wrap_write();
        int n;
        logic ps;
        cfg_write(0, 5, 1'b0);
        cfg_write(0, 5, 1'b1);
        repeat (4) tick_clk();
        cfg_write(0, 7, 1'b1);
        n_vec++;
        if ({tick[0], pend[0]} !== 2'b10) begin
            n_err++;
            $display("FAIL wrap_write_edge: tick/pend=%b, required 10", {tick[0], pend[0]});
        end
        edges_to_tick(0, 20, n, ps);
        n_vec++;
        if (n !== 7 || ps !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_write_period: period=%0d pend_seen=%b, required 7 and 0", n, ps);
        end
    endtask

    task automatic test_reset_mid();
        cfg_write(1, 10, 1'b0);
        cfg_write(1, 10, 1'b1);
        tick_clk();
        cfg_write(1, 20, 1'b1);
        n_vec++;
        if (pend[1] !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_setup: pend=%b, required 1", pend[1]);
        end
        reset = 1'b1;
        set_cfg(1'b1, 1, 5, 1'b1);
        repeat (3) begin
            tick_clk();
            n_vec++;
            if ({cfg_if.cfg_ready, tick, sq, pend} !== '0) begin
                n_err++;
                $display("FAIL reset_mid_state: ready=%b tick=%b sq=%b pend=%b, required all 0",
                         cfg_if.cfg_ready, tick, sq, pend);
            end
        end
        reset = 1'b0;
        set_cfg(1'b0, 0, 0, 1'b0);
        for (int e = 1; e <= 25; e++) begin
            tick_clk();
            n_vec++;
            if (tick !== ((e == 25) ? {CH{1'b1}} : {CH{1'b0}})) begin
                n_err++;
                $display("FAIL reset_mid_restart: edge E%0d tick=%b", e, tick);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            set_cfg(1'($urandom_range(0, 1)), int'($urandom_range(0, CH - 1)),
                    int'($urandom_range(0, 9)), ($urandom_range(0, 3) != 0));
            step = CH'($urandom);
            #1;
            n_vec++;
            if (cfg_if.cfg_ready !== exp_ready()) begin
                n_err++;
                $display("FAIL random_ready: iter %0d ready=%b, required %b",
                         n, cfg_if.cfg_ready, exp_ready());
            end
            tick_clk();
            n_vec++;
            if ({tick, sq, pend} !== {m_tick, m_sq, m_pend}) begin
                n_err++;
                $display("FAIL random_outputs: iter %0d tick/sq/pend=%b/%b/%b, required %b/%b/%b",
                         n, tick, sq, pend, m_tick, m_sq, m_pend);
            end
        end
        reset = 1'b0;
        step = '0;
        set_cfg(1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_deferred();
        test_div01();
        test_step();
        test_wrap_write();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
